// File: rtl/mid_result_reader_pkg.sv
// mid_result_reader_pkg
// Shared definitions for the intermediate-result SRAM read/write control:
//   - state_t        : drain/fill sequencing states (IDLE/REQ/CAPT/STREAM/FIN)
//   - NUM_BANKS_DEF  : default number of SRAM banks (row width in words)
//   - DATA_WIDTH_DEF : default word width (signed two's complement)
//   - IDX_WIDTH      : width of the element index carried on the stream
package mid_result_reader_pkg;

  localparam int NUM_BANKS_DEF  = 64;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int IDX_WIDTH      = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    CAPT   = 3'd2,
    STREAM = 3'd3,
    FIN    = 3'd4
  } state_t;

endpackage

// File: rtl/mid_result_reader_if.sv
// mid_result_reader_if
// Valid/ready element stream leaving the result reader.
//   out_valid : word valid            (master -> slave)
//   out_ready : downstream accepts    (slave  -> master)
//   out_data  : element value         (master -> slave)
//   out_index : element index n       (master -> slave)
//   out_last  : final element marker  (master -> slave)
interface mid_result_reader_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [7:0]            out_index;
  logic                  out_last;

  modport master (
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );
endinterface

// File: rtl/mid_result_reader_argmax_tracker.sv
// argmax_tracker
// Running signed maximum with index over a stream of handshaked words.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_clear       : new drain accepted; drops o_max_valid
//   i_valid       : a word was handshaked this cycle
//   i_first       : the handshaked word is the first of the drain
//   i_last        : the handshaked word is the final element
//   i_data        : word value (signed)
//   i_index       : word index
//   o_max_valid   : result valid, rises with the final word, held until i_clear
//   o_max_index   : index of the largest word (lowest index on ties)
//   o_max_value   : largest word value
module argmax_tracker #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic                  i_first,
  input  logic                  i_last,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [IDX_WIDTH-1:0]  i_index,
  output logic                  o_max_valid,
  output logic [IDX_WIDTH-1:0]  o_max_index,
  output logic [DATA_WIDTH-1:0] o_max_value
);

  logic                  r_max_valid;
  logic [IDX_WIDTH-1:0]  r_max_index;
  logic [DATA_WIDTH-1:0] r_max_value;
  logic                  w_greater;

  // Strict compare keeps the earliest index when values tie.
  assign w_greater = $signed(i_data) > $signed(r_max_value);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max_valid <= 1'b0;
      r_max_index <= '0;
      r_max_value <= '0;
    end else if (i_clear) begin
      r_max_valid <= 1'b0;
    end else if (i_valid) begin
      if (i_first || w_greater) begin
        r_max_index <= i_index;
        r_max_value <= i_data;
      end
      if (i_last) begin
        r_max_valid <= 1'b1;
      end
    end
  end

  assign o_max_valid = r_max_valid;
  assign o_max_index = r_max_index;
  assign o_max_value = r_max_value;

endmodule

// File: rtl/mid_result_reader.sv
// mid_result_reader
// Drains the banked intermediate-result SRAM row by row and serialises each
// row as an ordered valid/ready element stream. Element n lives at bank
// n % NUM_BANKS, address n / NUM_BANKS; the final row may be partial.
// Optional feature: define ARGMAX_EN to track the signed argmax of the
// drained elements; when undefined the max_* outputs are tied to 0.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle drain request, honoured only in IDLE
//   busy       : high from the cycle after an accepted start through done
//   done       : one-cycle pulse after the final stream handshake
//   mem_addr   : shared read address to all banks
//   mem_rdata  : concatenated bank outputs, one cycle after mem_addr
//   out_if     : element stream (valid/ready, data, index, last)
//   max_valid, max_index, max_value : argmax result
module mid_result_reader
  import mid_result_reader_pkg::*;
#(
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_WORDS  = 200
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] mem_rdata,
  mid_result_reader_if.master             out_if,
  output logic                            max_valid,
  output logic [IDX_WIDTH-1:0]            max_index,
  output logic [DATA_WIDTH-1:0]           max_value
);

  localparam int BANK_W = $clog2(NUM_BANKS);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_row;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [IDX_WIDTH-1:0]  r_n;
  logic [BANK_W-1:0]     r_bank;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_rowbuf [NUM_BANKS];

  logic                  w_hs;
  logic                  w_is_last;
  logic                  w_start_ok;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_hs       = r_valid && out_if.out_ready;
  assign w_is_last  = (r_n == IDX_WIDTH'(NUM_WORDS - 1));
  assign w_start_ok = (r_state == IDLE) && start;
  assign w_word     = r_rowbuf[r_bank];

  // Sequencer. mem_addr is loaded on the transition into REQ so the SRAM
  // sees the row address during the REQ cycle and returns data in CAPT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_mem_addr <= '0;
      r_n        <= '0;
      r_bank     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_mem_addr <= '0;
          if (start) begin
            r_state <= REQ;
            r_row   <= '0;
            r_n     <= '0;
            r_bank  <= '0;
            r_busy  <= 1'b1;
          end
        end
        REQ: begin
          r_state <= CAPT;
        end
        CAPT: begin
          r_state <= STREAM;
          r_valid <= 1'b1;
        end
        STREAM: begin
          if (w_hs) begin
            r_n <= r_n + 1'b1;
            if (w_is_last) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FIN;
            end else if (r_bank == BANK_W'(NUM_BANKS - 1)) begin
              r_valid    <= 1'b0;
              r_bank     <= '0;
              r_row      <= r_row + 1'b1;
              r_mem_addr <= r_row + 1'b1;
              r_state    <= REQ;
            end else begin
              r_bank <= r_bank + 1'b1;
            end
          end
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Row buffer: one word per bank, captured while the SRAM output is valid.
  // Contents only reach the outputs while out_valid is high, so no reset.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_rowbuf
      always_ff @(posedge clk) begin
        if (r_state == CAPT) begin
          r_rowbuf[gi] <= mem_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  endgenerate

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_addr = r_mem_addr;

  // Stream fields are forced to 0 outside STREAM so idle/reset outputs are 0.
  assign out_if.out_valid = r_valid;
  assign out_if.out_data  = r_valid ? w_word : '0;
  assign out_if.out_index = r_valid ? r_n : '0;
  assign out_if.out_last  = r_valid && w_is_last;

`ifdef ARGMAX_EN
  argmax_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_argmax (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start_ok),
    .i_valid     (w_hs),
    .i_first     (r_n == '0),
    .i_last      (w_is_last),
    .i_data      (w_word),
    .i_index     (r_n),
    .o_max_valid (max_valid),
    .o_max_index (max_index),
    .o_max_value (max_value)
  );
`else
  logic w_unused;
  assign w_unused  = w_start_ok;
  assign max_valid = 1'b0;
  assign max_index = '0;
  assign max_value = '0;
`endif

endmodule
